// File: rtl/bj_pkg.sv
// Shared blackjack types and constants used by the dealer and the hand-scoring logic.
package bj_pkg;

  localparam int RANK_MIN    = 1;
  localparam int RANK_MAX    = 13;
  localparam int ACE_POINTS  = 11;
  localparam int FACE_POINTS = 10;

  typedef logic [3:0] rank_t;
  typedef logic [4:0] points_t;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    SCAN
  } dealer_state_t;

endpackage

// File: rtl/rank_to_points.sv
// Combinational rank to blackjack points: ace counts 11, court cards 10, others face value.
module rank_to_points
  import bj_pkg::*;
(
  input  rank_t   rank,
  output points_t points,
  output logic    is_ace
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    points = '0;
    is_ace = 1'b0;
    if (rank == rank_t'(RANK_MIN)) begin
      points = points_t'(ACE_POINTS);
      is_ace = 1'b1;
    end else if (rank >= rank_t'(FACE_POINTS) && rank <= rank_t'(RANK_MAX)) begin
      points = points_t'(FACE_POINTS);
    end else if (rank > rank_t'(RANK_MIN) && rank < rank_t'(FACE_POINTS)) begin
      points = {1'b0, rank};
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Deals legal cards from a finite shoe using a random nibble stream, with a deterministic
// ascending scan once too many samples have been rejected.
module card_dealer
  import bj_pkg::*;
#(
  parameter int NUM_DECKS = 1,
  parameter int MAX_TRIES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rnd,
  input  logic       shuffle,
  input  logic       draw_req,
  output logic       busy,
  output logic       card_valid,
  output rank_t      card_rank,
  output points_t    card_points,
  output logic       card_is_ace,
  output logic       empty_err,
  output logic [8:0] cards_left
);

  localparam logic [5:0] RANK_FULL = 6'(4 * NUM_DECKS);
  localparam logic [8:0] SHOE_FULL = 9'(52 * NUM_DECKS);
  localparam logic [7:0] TRY_LIMIT = 8'(MAX_TRIES);

  dealer_state_t state, state_next;
  logic [5:0]    rank_cnt [RANK_MAX];
  logic [15:0]   avail;
  logic [7:0]    try_cnt;
  rank_t         scan_idx, cand, pick;
  logic          pending, deal, empty_hit;
  points_t       pick_points;
  logic          pick_ace;

  // avail is indexed directly by a raw nibble; 0, 14 and 15 are never available.
  always_comb begin
    avail = '0;
    for (int i = 0; i < RANK_MAX; i++) avail[i+1] = (rank_cnt[i] != '0);
  end

  assign cand = (state == SCAN) ? scan_idx : rnd;
  assign busy = (state != IDLE) || pending;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst)          state <= IDLE;
    else if (shuffle) state <= IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next = state;
    deal       = 1'b0;
    empty_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (draw_req && !pending) begin
          if (cards_left != '0) state_next = SAMPLE;
          else                  empty_hit  = 1'b1;
        end
      end
      SAMPLE: begin
        // A spent try budget costs one cycle to hand over to the scan.
        if (try_cnt == TRY_LIMIT) begin
          state_next = SCAN;
        end else if (avail[cand]) begin
          deal       = 1'b1;
          state_next = IDLE;
        end
      end
      SCAN: begin
        if (avail[cand]) begin
          deal       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  rank_to_points u_points (
    .rank   (pick),
    .points (pick_points),
    .is_ace (pick_ace)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the rank counters are a handful of flops, not a RAM, so resetting them is cheap and required.
      for (int i = 0; i < RANK_MAX; i++) rank_cnt[i] <= RANK_FULL;
      cards_left  <= SHOE_FULL;
      try_cnt     <= '0;
      scan_idx    <= rank_t'(RANK_MIN);
      pick        <= '0;
      pending     <= 1'b0;
      card_valid  <= 1'b0;
      card_rank   <= '0;
      card_points <= '0;
      card_is_ace <= 1'b0;
      empty_err   <= 1'b0;
    end else begin
      card_valid <= 1'b0;
      empty_err  <= 1'b0;
      pending    <= 1'b0;
      if (shuffle) begin
        for (int i = 0; i < RANK_MAX; i++) rank_cnt[i] <= RANK_FULL;
        cards_left <= SHOE_FULL;
      end else begin
        if (deal) begin
          for (int i = 0; i < RANK_MAX; i++)
            if (cand == rank_t'(i + 1)) rank_cnt[i] <= rank_cnt[i] - 6'd1;
          cards_left <= cards_left - 9'd1;
          pick       <= cand;
        end
        pending   <= deal;
        empty_err <= empty_hit;
        // The card is presented one cycle after the shoe is updated.
        if (pending) begin
          card_valid  <= 1'b1;
          card_rank   <= pick;
          card_points <= pick_points;
          card_is_ace <= pick_ace;
        end
      end
      if (state != SAMPLE)                    try_cnt <= '0;
      else if (!deal && try_cnt != TRY_LIMIT) try_cnt <= try_cnt + 8'd1;
      if (state != SCAN) scan_idx <= rank_t'(RANK_MIN);
      else               scan_idx <= scan_idx + rank_t'(1);
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: fixed draw table, randomized shoe drain against a transaction-level
// shoe model, and hand-written shuffle / empty / reset sequences.
module tb_card_dealer;
  import bj_pkg::*;

  localparam int NUM_DECKS = 1;
  localparam int MAX_TRIES = 16;

  logic       clk, rst, shuffle, draw_req;
  logic [3:0] rnd;
  logic       busy, card_valid, card_is_ace, empty_err;
  rank_t      card_rank;
  points_t    card_points;
  logic [8:0] cards_left;

  card_dealer #(.NUM_DECKS(NUM_DECKS), .MAX_TRIES(MAX_TRIES)) dut (
    .clk         (clk),
    .rst         (rst),
    .rnd         (rnd),
    .shuffle     (shuffle),
    .draw_req    (draw_req),
    .busy        (busy),
    .card_valid  (card_valid),
    .card_rank   (card_rank),
    .card_points (card_points),
    .card_is_ace (card_is_ace),
    .empty_err   (empty_err),
    .cards_left  (cards_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Shoe model: remaining copies per rank and the rnd value offered on each sampling cycle.
  int model_cnt [14];
  int model_left;
  int rnd_list [MAX_TRIES];
  int last_rank;

  typedef struct {
    int rnd;
    int rank;
    int points;
    int ace;
    int lat;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_refill();
    for (int r = 1; r <= 13; r++) model_cnt[r] = 4 * NUM_DECKS;
    model_left = 52 * NUM_DECKS;
  endfunction

  function automatic int model_points(input int r);
    if (r == 1)  return 11;
    if (r >= 10) return 10;
    return r;
  endfunction

  // One draw: first acceptable sample wins (latency t+2); after MAX_TRIES rejects a one-cycle
  // handover then an ascending scan reaches rank r after r cycles (latency MAX_TRIES+2+r).
  task automatic model_draw(output int r, output int lat);
    r   = 0;
    lat = 0;
    for (int t = 0; t < MAX_TRIES && r == 0; t++) begin
      if (rnd_list[t] >= 1 && rnd_list[t] <= 13 && model_cnt[rnd_list[t]] > 0) begin
        r   = rnd_list[t];
        lat = t + 2;
      end
    end
    for (int s = 1; s <= 13 && r == 0; s++) begin
      if (model_cnt[s] > 0) begin
        r   = s;
        lat = MAX_TRIES + 2 + s;
      end
    end
    model_cnt[r]--;
    model_left--;
    last_rank = r;
  endtask

  task automatic do_draw(input string tag, output int lat);
    int exp_r, exp_lat;
    bit got;
    model_draw(exp_r, exp_lat);
    draw_req = 1'b1;
    rnd      = 4'($urandom);
    step();
    draw_req = 1'b0;
    rnd      = 4'(rnd_list[0]);
    check($sformatf("%s busy", tag), busy, 1);
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      step();
      if (card_valid) begin
        got      = 1'b1;
        lat      = k;
        draw_req = 1'b0;
      end else begin
        rnd      = (k < MAX_TRIES) ? 4'(rnd_list[k]) : 4'($urandom);
        draw_req = 1'($urandom_range(0, 1));
      end
    end
    draw_req = 1'b0;
    check($sformatf("%s latency", tag), lat, exp_lat);
    check($sformatf("%s rank", tag), card_rank, exp_r);
    check($sformatf("%s points", tag), card_points, model_points(exp_r));
    check($sformatf("%s ace", tag), card_is_ace, (exp_r == 1) ? 1 : 0);
    check($sformatf("%s cards_left", tag), cards_left, model_left);
    step();
    check($sformatf("%s valid pulse", tag), card_valid, 0);
    check($sformatf("%s busy done", tag), busy, 0);
  endtask

  initial begin
    int lat;
    int pulses;

    tbl[0]  = '{5,  5,  5,  0, 2};
    tbl[1]  = '{12, 12, 10, 0, 2};
    tbl[2]  = '{1,  1,  11, 1, 2};
    tbl[3]  = '{13, 13, 10, 0, 2};
    tbl[4]  = '{10, 10, 10, 0, 2};
    tbl[5]  = '{2,  2,  2,  0, 2};
    tbl[6]  = '{15, 1,  11, 1, 19};
    tbl[7]  = '{0,  1,  11, 1, 19};
    tbl[8]  = '{14, 1,  11, 1, 19};
    tbl[9]  = '{7,  7,  7,  0, 2};
    tbl[10] = '{7,  7,  7,  0, 2};
    tbl[11] = '{7,  7,  7,  0, 2};
    tbl[12] = '{7,  7,  7,  0, 2};
    tbl[13] = '{7,  2,  2,  0, 20};
    tbl[14] = '{7,  2,  2,  0, 20};

    rst = 1'b1; shuffle = 1'b0; draw_req = 1'b0; rnd = 4'd0;
    model_refill();
    #12;
    check("reset busy", busy, 0);
    check("reset card_valid", card_valid, 0);
    check("reset card_rank", card_rank, 0);
    check("reset card_points", card_points, 0);
    check("reset card_is_ace", card_is_ace, 0);
    check("reset empty_err", empty_err, 0);
    check("reset cards_left", cards_left, 52 * NUM_DECKS);
    rst = 1'b0;
    step();

    // Fixed rnd held per draw, including exhaustion of ranks 1 and 7.
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < MAX_TRIES; k++) rnd_list[k] = tbl[i].rnd;
      do_draw($sformatf("tbl%0d", i), lat);
      check($sformatf("tbl%0d table latency", i), lat, tbl[i].lat);
      check($sformatf("tbl%0d table rank", i), card_rank, tbl[i].rank);
      check($sformatf("tbl%0d table points", i), card_points, tbl[i].points);
      check($sformatf("tbl%0d table ace", i), card_is_ace, tbl[i].ace);
    end
    check("table cards_left", cards_left, 52 * NUM_DECKS - 15);

    shuffle = 1'b1;
    step();
    shuffle = 1'b0;
    model_refill();
    check("shuffle refill", cards_left, 52 * NUM_DECKS);

    // Random drain of the whole shoe.
    for (int i = 0; i < 52 * NUM_DECKS; i++) begin
      for (int k = 0; k < MAX_TRIES; k++) rnd_list[k] = $urandom_range(0, 15);
      do_draw($sformatf("rnd%0d", i), lat);
    end
    check("drained cards_left", cards_left, 0);

    draw_req = 1'b1;
    step();
    draw_req = 1'b0;
    check("empty_err pulse", empty_err, 1);
    check("empty busy", busy, 0);
    step();
    check("empty_err clears", empty_err, 0);
    check("empty no card", card_valid, 0);
    check("empty cards_left", cards_left, 0);
    check("rank holds", card_rank, last_rank);
    shuffle = 1'b1;
    step();
    shuffle = 1'b0;
    model_refill();
    check("refill after empty", cards_left, 52 * NUM_DECKS);

    // Shuffle aborts a draw stuck sampling rejects.
    draw_req = 1'b1;
    step();
    draw_req = 1'b0;
    rnd      = 4'd14;
    step();
    step();
    check("abort busy before", busy, 1);
    shuffle = 1'b1;
    step();
    shuffle = 1'b0;
    check("abort busy drops", busy, 0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (card_valid) pulses++;
      step();
    end
    check("abort no card", pulses, 0);
    check("abort cards_left", cards_left, 52 * NUM_DECKS);

    // Shuffle and draw_req together: the draw is dropped.
    shuffle  = 1'b1;
    draw_req = 1'b1;
    rnd      = 4'd5;
    step();
    shuffle  = 1'b0;
    draw_req = 1'b0;
    check("shuffle wins busy", busy, 0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (card_valid || busy) pulses++;
    end
    check("shuffle wins no draw", pulses, 0);
    check("shuffle wins cards_left", cards_left, 52 * NUM_DECKS);

    // Reset in the middle of a draw.
    for (int k = 0; k < MAX_TRIES; k++) rnd_list[k] = 3;
    do_draw("pre_rst", lat);
    draw_req = 1'b1;
    step();
    draw_req = 1'b0;
    rnd      = 4'd15;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check("rst busy", busy, 0);
    check("rst cards_left", cards_left, 52 * NUM_DECKS);
    check("rst card_rank", card_rank, 0);
    check("rst card_points", card_points, 0);
    #2 rst = 1'b0;
    model_refill();
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (card_valid) pulses++;
    end
    check("rst no card", pulses, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
